// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached RAM slave: frame opcodes, FSM states
// and the payload-width helper used to size the rx frame.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_PIPE = 2'b01,
    TX_HOLD = 2'b10
  } state_e;

  // The payload field has to carry either an address or a data word.
  function automatic int pay_width(input int addr_size, input int mem_width);
    return (addr_size > mem_width) ? addr_size : mem_width;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous RAM with one write port and one registered read port.
// Out-of-range writes are ignored; out-of-range reads return zero.
// The read register doubles as the read-data stage for the slave.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [MEM_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0] rd_data
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic                 wr_in_range;
  logic                 rd_in_range;

  assign wr_in_range = 32'(wr_addr) < MEM_DEPTH;
  assign rd_in_range = 32'(rd_addr) < MEM_DEPTH;

  // Storage array: optional clear on reset, otherwise in-range writes only.
  always_ff @(posedge clk) begin
    if (rst && (CLR_ON_RST != 0)) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: samples the pre-write contents, giving a snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/spi_ram_slave_p.sv
// SPI RAM slave: decodes opcode frames into address-set, write and read
// operations, returns read data over a valid/ready handshake and keeps
// sticky range/overflow error flags.
module spi_ram_slave_p
  import spi_ram_pkg::*;
#(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int AUTO_INC   = 1,
  parameter int READ_LAT   = 1,
  parameter int CLR_ON_RST = 1,
  localparam int PAY_W     = pay_width(ADDR_SIZE, MEM_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PAY_W+1:0]   rx_data,
  input  logic               rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               err_clr,
  output logic               err_range,
  output logic               err_ovf
);

  op_e                  opcode;
  logic [ADDR_SIZE-1:0] addr_payload;
  logic [MEM_WIDTH-1:0] data_payload;
  logic [ADDR_SIZE-1:0] write_addr;
  logic [ADDR_SIZE-1:0] read_addr;
  logic [MEM_WIDTH-1:0] stage_data;
  logic [MEM_WIDTH-1:0] tx_q;
  state_e               state_q;
  state_e               state_d;
  logic                 wr_fire;
  logic                 read_req;
  logic                 read_accept;
  logic                 read_drop;
  logic                 load_tx;
  logic                 waddr_ok;
  logic                 raddr_ok;
  logic                 range_hit;

  // Address wraps to zero after the last word, and from any out-of-range value.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) >= MEM_DEPTH - 1) return '0;
    return a + ADDR_SIZE'(1);
  endfunction

  assign opcode       = op_e'(rx_data[PAY_W+1:PAY_W]);
  assign addr_payload = rx_data[ADDR_SIZE-1:0];
  assign data_payload = rx_data[MEM_WIDTH-1:0];
  assign wr_fire      = rx_valid && (opcode == OP_WRITE);
  assign read_req     = rx_valid && (opcode == OP_READ);
  assign read_drop    = read_req && !read_accept;
  assign waddr_ok     = 32'(write_addr) < MEM_DEPTH;
  assign raddr_ok     = 32'(read_addr) < MEM_DEPTH;
  assign range_hit    = (wr_fire && !waddr_ok) || (read_accept && !raddr_ok);

  spi_ram_mem #(
    .MEM_WIDTH (MEM_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .CLR_ON_RST(CLR_ON_RST)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_fire && !rst),
    .wr_addr(write_addr),
    .wr_data(data_payload),
    .rd_en  (read_accept && !rst),
    .rd_addr(read_addr),
    .rd_data(stage_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: reads are only taken in IDLE, the rest are dropped.
  always_comb begin
    state_d     = state_q;
    read_accept = 1'b0;
    load_tx     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_req) begin
          read_accept = 1'b1;
          state_d     = (READ_LAT == 2) ? RD_PIPE : TX_HOLD;
        end
      end
      RD_PIPE: begin
        load_tx = 1'b1;
        state_d = TX_HOLD;
      end
      TX_HOLD: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write and read address counters driven by the frame decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_addr <= '0;
      read_addr  <= '0;
    end else if (rx_valid) begin
      unique case (opcode)
        OP_SET_WADDR: write_addr <= addr_payload;
        OP_WRITE:     if (AUTO_INC != 0) write_addr <= next_addr(write_addr);
        OP_SET_RADDR: read_addr <= addr_payload;
        OP_READ:      if (read_accept && (AUTO_INC != 0)) read_addr <= next_addr(read_addr);
        default:      ;
      endcase
    end
  end

  // Second pipeline stage, only meaningful when the read latency is two.
  always_ff @(posedge clk) begin
    if (rst)          tx_q <= '0;
    else if (load_tx) tx_q <= stage_data;
  end

  assign tx_data  = (READ_LAT == 2) ? tx_q : stage_data;
  assign tx_valid = (state_q == TX_HOLD);

  // Sticky error flags: a new error on the clearing edge still sets the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (range_hit)    err_range <= 1'b1;
      else if (err_clr) err_range <= 1'b0;
      if (read_drop)    err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Bench for spi_ram_slave_p: three instances (default, two-cycle read
// latency, 200-word depth) with a per-instance read-data scoreboard.
module tb_spi_ram_slave_p;
  import spi_ram_pkg::*;

  logic clk;
  int   checks;
  int   failures;

  logic       a_rst, a_rx_valid, a_tx_valid, a_tx_ready, a_err_clr, a_err_range, a_err_ovf;
  logic [9:0] a_rx_data;
  logic [7:0] a_tx_data;
  logic       b_rst, b_rx_valid, b_tx_valid, b_tx_ready, b_err_clr, b_err_range, b_err_ovf;
  logic [9:0] b_rx_data;
  logic [7:0] b_tx_data;
  logic       c_rst, c_rx_valid, c_tx_valid, c_tx_ready, c_err_clr, c_err_range, c_err_ovf;
  logic [9:0] c_rx_data;
  logic [7:0] c_tx_data;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  spi_ram_slave_p dut_a (
    .clk(clk), .rst(a_rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .err_clr(a_err_clr), .err_range(a_err_range), .err_ovf(a_err_ovf)
  );

  spi_ram_slave_p #(.READ_LAT(2)) dut_b (
    .clk(clk), .rst(b_rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .err_clr(b_err_clr), .err_range(b_err_range), .err_ovf(b_err_ovf)
  );

  spi_ram_slave_p #(.MEM_DEPTH(200)) dut_c (
    .clk(clk), .rst(c_rst), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .err_clr(c_err_clr), .err_range(c_err_range), .err_ovf(c_err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboards: each handshake about to complete pops one expected word.
  always @(negedge clk) begin
    if (!a_rst && a_tx_valid && a_tx_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++; $display("[TB] FAIL a_scoreboard: got %h with no expected read queued", a_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (a_tx_data !== e) begin
          failures++; $display("[TB] FAIL a_scoreboard: got %h expected %h", a_tx_data, e);
        end
      end
    end
    if (!b_rst && b_tx_valid && b_tx_ready) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++; $display("[TB] FAIL b_scoreboard: got %h with no expected read queued", b_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        if (b_tx_data !== e) begin
          failures++; $display("[TB] FAIL b_scoreboard: got %h expected %h", b_tx_data, e);
        end
      end
    end
    if (!c_rst && c_tx_valid && c_tx_ready) begin
      checks++;
      if (exp_c.size() == 0) begin
        failures++; $display("[TB] FAIL c_scoreboard: got %h with no expected read queued", c_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_c.pop_front();
        if (c_tx_data !== e) begin
          failures++; $display("[TB] FAIL c_scoreboard: got %h expected %h", c_tx_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [9:0] f);
    a_rx_data = f; a_rx_valid = 1'b1; step(); a_rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] f);
    b_rx_data = f; b_rx_valid = 1'b1; step(); b_rx_valid = 1'b0;
  endtask

  task automatic send_c(input logic [9:0] f);
    c_rx_data = f; c_rx_valid = 1'b1; step(); c_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs_a, obs_b, obs_c;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    obs_a = {a_tx_data, a_tx_valid, a_err_range, a_err_ovf, 1'b0};
    obs_b = {b_tx_data, b_tx_valid, b_err_range, b_err_ovf, 1'b0};
    obs_c = {c_tx_data, c_tx_valid, c_err_range, c_err_ovf, 1'b0};
    checks++;
    if (obs_a !== 12'h000) begin failures++; $display("[TB] FAIL reset_a: got %h expected 000", obs_a); end
    checks++;
    if (obs_b !== 12'h000) begin failures++; $display("[TB] FAIL reset_b: got %h expected 000", obs_b); end
    checks++;
    if (obs_c !== 12'h000) begin failures++; $display("[TB] FAIL reset_c: got %h expected 000", obs_c); end
  endtask

  task automatic test_write_read();
    a_tx_ready = 1'b1;
    send_a(10'h000); send_a(10'h1A5); send_a(10'h200);
    exp_a.push_back(8'hA5);
    send_a(10'h300);
    checks++;
    if (a_tx_valid !== 1'b1) begin failures++; $display("[TB] FAIL wr_rd_valid: got %b expected 1", a_tx_valid); end
    checks++;
    if (a_tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL wr_rd_data: got %h expected a5", a_tx_data); end
    step();
    checks++;
    if (a_tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL wr_rd_pulse: got %b expected 0", a_tx_valid); end
    checks++;
    if ({a_err_range, a_err_ovf} !== 2'b00) begin
      failures++; $display("[TB] FAIL wr_rd_errs: got %b expected 00", {a_err_range, a_err_ovf});
    end
  endtask

  task automatic test_auto_inc();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    a_tx_ready = 1'b1;
    send_a(10'h010); send_a(10'h111); send_a(10'h122); send_a(10'h133); send_a(10'h210);
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(vals[i]);
      send_a(10'h300);
      checks++;
      if (a_tx_data !== vals[i]) begin
        failures++; $display("[TB] FAIL burst_data%0d: got %h expected %h", i, a_tx_data, vals[i]);
      end
      step();
    end
    checks++;
    if (dut_a.read_addr !== 8'h13) begin failures++; $display("[TB] FAIL burst_raddr: got %h expected 13", dut_a.read_addr); end
    checks++;
    if (a_err_ovf !== 1'b0) begin failures++; $display("[TB] FAIL burst_ovf: got %b expected 0", a_err_ovf); end
  endtask

  task automatic test_backpressure();
    a_tx_ready = 1'b0;
    send_a(10'h210);
    exp_a.push_back(8'h11);
    send_a(10'h300);
    send_a(10'h300);
    checks++;
    if ({a_tx_valid, a_tx_data, a_err_ovf} !== {1'b1, 8'h11, 1'b1}) begin
      failures++; $display("[TB] FAIL bp_hold: got v=%b d=%h ovf=%b expected v=1 d=11 ovf=1", a_tx_valid, a_tx_data, a_err_ovf);
    end
    step(); step();
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h11}) begin
      failures++; $display("[TB] FAIL bp_stable: got v=%b d=%h expected v=1 d=11", a_tx_valid, a_tx_data);
    end
    checks++;
    if (dut_a.read_addr !== 8'h11) begin failures++; $display("[TB] FAIL bp_raddr: got %h expected 11", dut_a.read_addr); end
    a_tx_ready = 1'b1;
    step();
    checks++;
    if (a_tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release: got %b expected 0", a_tx_valid); end
    a_err_clr = 1'b1; step(); a_err_clr = 1'b0;
    checks++;
    if (a_err_ovf !== 1'b0) begin failures++; $display("[TB] FAIL bp_clear: got %b expected 0", a_err_ovf); end
  endtask

  task automatic test_back_to_back();
    a_tx_ready = 1'b1;
    send_a(10'h210);
    exp_a.push_back(8'h11);
    send_a(10'h300);
    send_a(10'h300);
    checks++;
    if ({a_tx_valid, a_err_ovf} !== 2'b01) begin
      failures++; $display("[TB] FAIL b2b_exit_drop: got v=%b ovf=%b expected v=0 ovf=1", a_tx_valid, a_err_ovf);
    end
    checks++;
    if (dut_a.read_addr !== 8'h11) begin failures++; $display("[TB] FAIL b2b_raddr: got %h expected 11", dut_a.read_addr); end
    a_err_clr = 1'b1; step(); a_err_clr = 1'b0;
    checks++;
    if (a_err_ovf !== 1'b0) begin failures++; $display("[TB] FAIL b2b_clear: got %b expected 0", a_err_ovf); end
    a_tx_ready = 1'b0;
    exp_a.push_back(8'h22);
    send_a(10'h300);
    a_err_clr = 1'b1;
    send_a(10'h300);
    a_err_clr = 1'b0;
    checks++;
    if (a_err_ovf !== 1'b1) begin failures++; $display("[TB] FAIL b2b_set_wins: got %b expected 1", a_err_ovf); end
    a_tx_ready = 1'b1;
    step();
    checks++;
    if (a_tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_release: got %b expected 0", a_tx_valid); end
    a_err_clr = 1'b1; step(); a_err_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_tx_ready = 1'b0;
    send_a(10'h200);
    send_a(10'h300);
    checks++;
    if (a_tx_valid !== 1'b1) begin failures++; $display("[TB] FAIL mrst_pending: got %b expected 1", a_tx_valid); end
    a_rst = 1'b1; step(); a_rst = 1'b0;
    checks++;
    if ({a_tx_valid, a_tx_data} !== 9'h000) begin
      failures++; $display("[TB] FAIL mrst_outputs: got v=%b d=%h expected v=0 d=00", a_tx_valid, a_tx_data);
    end
    checks++;
    if (dut_a.state_q !== IDLE) begin failures++; $display("[TB] FAIL mrst_state: got %0d expected %0d", dut_a.state_q, IDLE); end
    a_tx_ready = 1'b1;
    send_a(10'h200);
    exp_a.push_back(8'h00);
    send_a(10'h300);
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h00}) begin
      failures++; $display("[TB] FAIL mrst_cleared: got v=%b d=%h expected v=1 d=00", a_tx_valid, a_tx_data);
    end
    step();
  endtask

  task automatic test_lat2_snapshot();
    b_tx_ready = 1'b1;
    send_b(10'h005); send_b(10'h144); send_b(10'h205); send_b(10'h005);
    exp_b.push_back(8'h44);
    send_b(10'h300);
    checks++;
    if (b_tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat2_early: got %b expected 0", b_tx_valid); end
    send_b(10'h199);
    checks++;
    if ({b_tx_valid, b_tx_data} !== {1'b1, 8'h44}) begin
      failures++; $display("[TB] FAIL lat2_snapshot: got v=%b d=%h expected v=1 d=44", b_tx_valid, b_tx_data);
    end
    step();
    send_b(10'h205);
    exp_b.push_back(8'h99);
    send_b(10'h300);
    step();
    checks++;
    if ({b_tx_valid, b_tx_data} !== {1'b1, 8'h99}) begin
      failures++; $display("[TB] FAIL lat2_reread: got v=%b d=%h expected v=1 d=99", b_tx_valid, b_tx_data);
    end
    step();
  endtask

  task automatic test_range_wrap();
    c_tx_ready = 1'b1;
    send_c(10'h0C7); send_c(10'h177);
    checks++;
    if (dut_c.write_addr !== 8'h00) begin failures++; $display("[TB] FAIL rng_wrap: got %h expected 00", dut_c.write_addr); end
    checks++;
    if (c_err_range !== 1'b0) begin failures++; $display("[TB] FAIL rng_clean: got %b expected 0", c_err_range); end
    send_c(10'h2C7);
    exp_c.push_back(8'h77);
    send_c(10'h300);
    step();
    checks++;
    if (dut_c.read_addr !== 8'h00) begin failures++; $display("[TB] FAIL rng_rwrap: got %h expected 00", dut_c.read_addr); end
    send_c(10'h0C8); send_c(10'h155);
    checks++;
    if ({c_err_range, dut_c.write_addr} !== {1'b1, 8'h00}) begin
      failures++; $display("[TB] FAIL rng_wr_oob: got err=%b waddr=%h expected err=1 waddr=00", c_err_range, dut_c.write_addr);
    end
    exp_c.push_back(8'h00);
    send_c(10'h300);
    step();
    c_err_clr = 1'b1; step(); c_err_clr = 1'b0;
    checks++;
    if (c_err_range !== 1'b0) begin failures++; $display("[TB] FAIL rng_clear: got %b expected 0", c_err_range); end
    send_c(10'h2D0);
    exp_c.push_back(8'h00);
    send_c(10'h300);
    checks++;
    if ({c_tx_valid, c_tx_data, c_err_range} !== {1'b1, 8'h00, 1'b1}) begin
      failures++; $display("[TB] FAIL rng_rd_oob: got v=%b d=%h err=%b expected v=1 d=00 err=1", c_tx_valid, c_tx_data, c_err_range);
    end
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    a_rst = 1'b1; a_rx_data = '0; a_rx_valid = 1'b0; a_tx_ready = 1'b0; a_err_clr = 1'b0;
    b_rst = 1'b1; b_rx_data = '0; b_rx_valid = 1'b0; b_tx_ready = 1'b0; b_err_clr = 1'b0;
    c_rst = 1'b1; c_rx_data = '0; c_rx_valid = 1'b0; c_tx_ready = 1'b0; c_err_clr = 1'b0;
    test_reset();
    test_write_read();
    test_auto_inc();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_lat2_snapshot();
    test_range_wrap();
    step();
    checks++;
    if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d reads outstanding expected 0", exp_a.size() + exp_b.size() + exp_c.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
